fifo_tx_serializer: RTL and testbench
=====================================

# fifo_tx_serializer

Downstream consumer of the synchronous FIFO. It pops one word whenever the FIFO is non-empty and transmission is enabled. Each word is shifted out on a single-wire, UART-style serial line with start and stop framing, LSB first. The block drives the FIFO's read strobe directly and uses the FIFO's empty flag and read data as its only source.

## Interface
- `width`, default 16: data word width; must match the FIFO `width`.
- `clks_per_bit`, default 4: clock cycles per serial bit period; minimum 2.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_`  input  1: asynchronous, active-high reset.
- `tx_en`  input  1: when high, new frames may start; when low, the current frame completes and no new pop occurs.
- `fifo_empty`  input  1: FIFO empty flag.
- `fifo_data_out`  input  `width`: FIFO read data; valid the cycle after `fifo_read`.
- `fifo_read`  output  1: FIFO pop strobe; one-cycle pulse per frame.
- `ser_out`  output  1: serial line; idles high.
- `ser_busy`  output  1: high from POP through the end of STOP.
- `frame_done`  output  1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
- **IDLE**
  - `ser_out=1`.
  - If `tx_en && !fifo_empty`, go to POP; otherwise stay.
- **POP**: `fifo_read=1` for exactly this cycle; go to LOAD.
- **LOAD**: `shift_reg <= fifo_data_out`; bit counter cleared; go to START.
- **START**: `ser_out=0` for `clks_per_bit` cycles; go to DATA.
- **DATA**
  - `ser_out=shift_reg[0]`; shift right once per bit period.
  - After `width` bits, go to PARITY (macro defined) or STOP.
- **STOP**
  - `ser_out=1` for `clks_per_bit` cycles; `frame_done` on the last cycle.
  - Then go to POP if `tx_en && !fifo_empty`, else to IDLE.
- `fifo_read` is never asserted while `fifo_empty=1`, and never on two consecutive cycles.
- `tx_en` dropping mid-frame has no effect until the STOP decision point.
- Reset values, asynchronous and immediate:
  - `ser_out=1`, `fifo_read=0`, `ser_busy=0`, `frame_done=0`.
  - State IDLE; shift register, bit counter and baud counter all 0.
- Reset mid-frame aborts the frame and the already-popped word is discarded. `ser_out` returns high in the same instant the reset asserts.
- Width rules:
  - Bit counter is `$clog2(width+1)` bits.
  - Baud counter is `$clog2(clks_per_bit)` bits and wraps at `clks_per_bit-1`.
  - No other arithmetic.

## Timing
- Let cycle 0 be the POP cycle. LOAD is cycle 1 and the start bit begins at cycle 2.
- Frame length is `(width+2)*clks_per_bit` cycles, or `(width+3)*clks_per_bit` with parity.
- `frame_done` falls at cycle `1 + frame length`.
- Back-to-back frames are separated by exactly 2 idle-high cycles (POP, LOAD).
- `fifo_empty` is sampled only in IDLE and on the final STOP cycle.

## Configuration
- `FIFO_TX_PARITY_EN` defined:
  - PARITY state is compiled in; one extra bit period between DATA and STOP.
  - `ser_out = ^word`, i.e. even parity over the `width` data bits.
- `FIFO_TX_PARITY_EN` undefined: DATA goes directly to STOP; no parity logic exists.

## Structure
- Package `fifo_tx_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} tx_state_t`.
  - Constants `SER_IDLE_LEVEL=1'b1`, `SER_START_LEVEL=1'b0`.
- One sub-module, `fifo_tx_baud_tick`:
  - Counts the bit period and emits `bit_tick` on the last cycle of each period.
  - Cleared in LOAD.

## Test plan
- Reset, FIFO empty, `tx_en=1` → `ser_out=1`, `fifo_read` never asserted, `ser_busy=0` for 50 cycles.
- One word 16'h0003, `clks_per_bit=4`, no parity:
  - `fifo_read` at cycle 0; `ser_out` 0 on cycles 2–5, 1 on 6–13, 0 on 14–69, 1 on 70–73.
  - `frame_done` at cycle 73.
- Same word with `FIFO_TX_PARITY_EN`:
  - Parity bit 0 on cycles 70–73, stop on 74–77, `frame_done` at cycle 77.
- Three words preloaded (16'h0004, 16'h0005, 16'h0006):
  - Three `fifo_read` pulses 74 cycles apart.
  - Exactly 2 idle-high cycles between frames; bits in order.
- `tx_en` dropped mid-frame with 2 words queued:
  - Current frame completes, then IDLE with no further pop.
  - Raising `tx_en` pops on the next cycle.
- `rst_` asserted during DATA:
  - `ser_out=1` and `ser_busy=0` immediately.
  - After release, the next queued word transmits from its start bit.

Source files
------------

// File: rtl/fifo_tx_pkg.sv
// ----------------------------------------------------------------------------
// | Module      : fifo_tx_pkg                                                |
// | Description : Shared state encoding and serial line levels for the FIFO  |
// |               transmit serializer.                                       |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_tx_pkg;

  // PARITY is only reachable when FIFO_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic SER_IDLE_LEVEL  = 1'b1;
  localparam logic SER_START_LEVEL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/fifo_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// | Module      : fifo_tx_serializer_if                                      |
// | Description : FIFO read side plus serial line bundle. The master modport |
// |               is the serializer; the slave modport is the FIFO/system.   |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
`default_nettype none

interface fifo_tx_serializer_if #(
  parameter int WIDTH = 16
);

  logic             tx_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_read;
  logic             ser_out;
  logic             ser_busy;
  logic             frame_done;

  modport master (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data_out,
    output fifo_read,
    output ser_out,
    output ser_busy,
    output frame_done
  );

  modport slave (
    output tx_en,
    output fifo_empty,
    output fifo_data_out,
    input  fifo_read,
    input  ser_out,
    input  ser_busy,
    input  frame_done
  );

endinterface

`default_nettype wire

// File: rtl/fifo_tx_baud_tick.sv
// ----------------------------------------------------------------------------
// | Module      : fifo_tx_baud_tick                                          |
// | Description : Bit-period counter. Pulses bit_tick_o on the last cycle of |
// |               every bit period while running; cleared by clear_i.        |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_tx_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear_i,
  input  logic run_i,
  output logic bit_tick_o
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_tick_o = run_i && (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise count and wrap at the end of a period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = bit_tick_o ? '0 : (cnt_q + CNT_ONE);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_tx_serializer.sv
// ----------------------------------------------------------------------------
// | Module      : fifo_tx_serializer                                         |
// | Description : Pops words from a synchronous FIFO and shifts each out     |
// |               LSB first on a UART-style line (start, data, stop).        |
// |               Define FIFO_TX_PARITY_EN to insert an even parity bit      |
// |               between the data bits and the stop bit.                    |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_tx_serializer #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_,
  fifo_tx_serializer_if.master bus
);

  import fifo_tx_pkg::*;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_POP    = POP;
  localparam logic [2:0] ST_LOAD   = LOAD;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
`ifdef FIFO_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] ST_STOP   = STOP;

  localparam int                BCNT_W    = $clog2(WIDTH + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  shift_d;
  logic [BCNT_W-1:0] bit_cnt_q;
  logic [BCNT_W-1:0] bit_cnt_d;

  logic w_bit_tick;
  logic w_baud_run;
  logic w_baud_clear;
  logic w_start_ok;

  // A new frame may begin only when enabled and a word is waiting.
  assign w_start_ok   = bus.tx_en && !bus.fifo_empty;
  assign w_baud_clear = (state_q == ST_LOAD);
  assign w_baud_run   = (state_q == ST_START) || (state_q == ST_DATA) ||
`ifdef FIFO_TX_PARITY_EN
                        (state_q == ST_PARITY) ||
`endif
                        (state_q == ST_STOP);

  fifo_tx_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst_       (rst_),
    .clear_i    (w_baud_clear),
    .run_i      (w_baud_run),
    .bit_tick_o (w_bit_tick)
  );

  // Frame sequencing; the enable/empty decision is taken only in IDLE and
  // on the final stop cycle so a mid-frame tx_en drop never truncates a frame.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start_ok) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = bus.fifo_data_out;
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (w_bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          shift_d   = {1'b0, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BCNT_ONE;
          if (bit_cnt_q == BCNT_LAST) begin
`ifdef FIFO_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_tick) state_d = w_start_ok ? ST_POP : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register and bit counter; reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef FIFO_TX_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Even parity of the word is captured alongside it, since shifting destroys it.
  always_comb begin
    parity_d = parity_q;
    if (state_q == ST_LOAD) parity_d = ^bus.fifo_data_out;
  end

  // Parity register.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Line level decoded from state so reset forces the idle level at once.
  always_comb begin
    bus.ser_out = SER_IDLE_LEVEL;
    case (state_q)
      ST_START:  bus.ser_out = SER_START_LEVEL;
      ST_DATA:   bus.ser_out = shift_q[0];
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: bus.ser_out = parity_q;
`endif
      default:   bus.ser_out = SER_IDLE_LEVEL;
    endcase
  end

  assign bus.fifo_read  = (state_q == ST_POP);
  assign bus.ser_busy   = (state_q != ST_IDLE);
  assign bus.frame_done = (state_q == ST_STOP) && w_bit_tick;

endmodule

`default_nettype wire

// File: tb/tb_fifo_tx_serializer.sv
// ----------------------------------------------------------------------------
// | Module      : tb_fifo_tx_serializer                                      |
// | Description : Directed, self-checking bench for fifo_tx_serializer with  |
// |               a small FIFO read model and hand-computed frame vectors.   |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_tx_serializer;

  localparam int W   = 16;
  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int NPAR = 1;
  localparam int NVEC = 13;
`else
  localparam int NPAR = 0;
  localparam int NVEC = 13;
`endif
  localparam int FL   = (W + 2 + NPAR) * CPB;  // frame length in cycles
  localparam int LAST = 1 + FL;                // cycle index of frame_done
  localparam int TMAX = 256;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;

  fifo_tx_serializer_if #(.WIDTH(W)) bus ();

  fifo_tx_serializer #(
    .WIDTH        (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: preloaded array, read data valid the cycle after fifo_read.
  logic [W-1:0] fmem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_read) begin
      bus.fifo_data_out <= fmem[rd_ptr[4:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic tr_ser  [TMAX];
  logic tr_rd   [TMAX];
  logic tr_fd   [TMAX];
  logic tr_busy [TMAX];

  typedef struct {
    int   cyc;
    logic ser;
    logic rd;
    logic fd;
    logic busy;
  } vec_t;
  vec_t vtab [NVEC];

  task automatic check(input string name, input int c, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, c, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] word);
    fmem[wr_ptr[4:0]] = word;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits (bounded) for a pop, then records ncyc cycles starting at the POP cycle.
  task automatic capture(input int ncyc, input int drop_at, output int waited);
    waited = 0;
    while (bus.fifo_read !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (bus.fifo_read !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout: got no fifo_read, expected one within 300 cycles");
    end
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) bus.tx_en = 1'b0;
      tr_ser[c]  = bus.ser_out;
      tr_rd[c]   = bus.fifo_read;
      tr_fd[c]   = bus.frame_done;
      tr_busy[c] = bus.ser_busy;
    end
  endtask

  // Expected waveform of one frame whose POP cycle sits at trace index base.
  task automatic check_frame(input logic [W-1:0] word, input int base, input string tag);
    for (int c = 0; c <= LAST; c++) begin
      logic es;
      int   d;
      es = 1'b1;
      d  = c - 2 - CPB;
      if (c >= 2 && c < 2 + CPB) es = 1'b0;
      else if (d >= 0 && d < W * CPB) es = word[d / CPB];
      else if (NPAR == 1 && d >= W * CPB && d < (W + 1) * CPB) es = ^word;
      check({tag, "_ser_out"},    base + c, tr_ser[base + c],  es);
      check({tag, "_fifo_read"},  base + c, tr_rd[base + c],   (c == 0));
      check({tag, "_frame_done"}, base + c, tr_fd[base + c],   (c == LAST));
      check({tag, "_ser_busy"},   base + c, tr_busy[base + c], 1'b1);
    end
  endtask

  initial begin
    int w;

    // Hand-computed checkpoints for word 16'h0003 (POP at cycle 0).
    vtab[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b1};
    vtab[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1};
    vtab[2]  = '{2,  1'b0, 1'b0, 1'b0, 1'b1};
    vtab[3]  = '{5,  1'b0, 1'b0, 1'b0, 1'b1};
    vtab[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b1};
    vtab[5]  = '{13, 1'b1, 1'b0, 1'b0, 1'b1};
    vtab[6]  = '{14, 1'b0, 1'b0, 1'b0, 1'b1};
    vtab[7]  = '{69, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef FIFO_TX_PARITY_EN
    vtab[8]  = '{70, 1'b0, 1'b0, 1'b0, 1'b1};
    vtab[9]  = '{73, 1'b0, 1'b0, 1'b0, 1'b1};
    vtab[10] = '{74, 1'b1, 1'b0, 1'b0, 1'b1};
    vtab[11] = '{77, 1'b1, 1'b0, 1'b1, 1'b1};
    vtab[12] = '{78, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    vtab[8]  = '{70, 1'b1, 1'b0, 1'b0, 1'b1};
    vtab[9]  = '{71, 1'b1, 1'b0, 1'b0, 1'b1};
    vtab[10] = '{72, 1'b1, 1'b0, 1'b0, 1'b1};
    vtab[11] = '{73, 1'b1, 1'b0, 1'b1, 1'b1};
    vtab[12] = '{74, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

    // Reset with an empty FIFO and transmission enabled.
    bus.tx_en = 1'b1;
    rst_      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ser_out",    0, bus.ser_out,    1'b1);
    check("rst_fifo_read",  0, bus.fifo_read,  1'b0);
    check("rst_ser_busy",   0, bus.ser_busy,   1'b0);
    check("rst_frame_done", 0, bus.frame_done, 1'b0);
    rst_ = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_ser_out",   i, bus.ser_out,   1'b1);
      check("idle_fifo_read", i, bus.fifo_read, 1'b0);
      check("idle_ser_busy",  i, bus.ser_busy,  1'b0);
    end

    // Single word, table-driven checkpoints plus the full frame model.
    push(16'h0003);
    capture(LAST + 2, -1, w);
    for (int i = 0; i < NVEC; i++) begin
      check("vec_ser_out",    vtab[i].cyc, tr_ser[vtab[i].cyc],  vtab[i].ser);
      check("vec_fifo_read",  vtab[i].cyc, tr_rd[vtab[i].cyc],   vtab[i].rd);
      check("vec_frame_done", vtab[i].cyc, tr_fd[vtab[i].cyc],   vtab[i].fd);
      check("vec_ser_busy",   vtab[i].cyc, tr_busy[vtab[i].cyc], vtab[i].busy);
    end
    check_frame(16'h0003, 0, "one");

    // Three preloaded words, back to back, pops LAST+1 cycles apart.
    push(16'h0004);
    push(16'h0005);
    push(16'h0006);
    capture(3 * (LAST + 1) + 1, -1, w);
    check_frame(16'h0004, 0,              "b2b0");
    check_frame(16'h0005, LAST + 1,       "b2b1");
    check_frame(16'h0006, 2 * (LAST + 1), "b2b2");
    check("b2b_end_busy", 3 * (LAST + 1), tr_busy[3 * (LAST + 1)], 1'b0);
    check("b2b_end_read", 3 * (LAST + 1), tr_rd[3 * (LAST + 1)],   1'b0);

    // tx_en dropped mid-frame with a second word still queued.
    push(16'h00A5);
    push(16'h5A5A);
    capture(LAST + 2, 20, w);
    check_frame(16'h00A5, 0, "txen");
    check("txen_after_busy", LAST + 1, tr_busy[LAST + 1], 1'b0);
    check("txen_after_read", LAST + 1, tr_rd[LAST + 1],   1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("txen_hold_read", i, bus.fifo_read, 1'b0);
      check("txen_hold_busy", i, bus.ser_busy,  1'b0);
      check("txen_hold_ser",  i, bus.ser_out,   1'b1);
    end
    bus.tx_en = 1'b1;
    @(negedge clk);
    check("txen_repop_read", 0, bus.fifo_read, 1'b1);
    capture(LAST + 2, -1, w);
    check_frame(16'h5A5A, 0, "repop");

    // Reset during DATA discards the popped word; the next one goes out whole.
    push(16'h1234);
    push(16'h00FF);
    capture(31, -1, w);
    check("prerst_ser_out", 30, tr_ser[30], 1'b0);
    #2 rst_ = 1'b1;
    #1;
    check("midrst_ser_out",    0, bus.ser_out,    1'b1);
    check("midrst_ser_busy",   0, bus.ser_busy,   1'b0);
    check("midrst_fifo_read",  0, bus.fifo_read,  1'b0);
    check("midrst_frame_done", 0, bus.frame_done, 1'b0);
    @(negedge clk);
    rst_ = 1'b0;
    capture(LAST + 2, -1, w);
    check_frame(16'h00FF, 0, "postrst");
    check("postrst_end_busy", LAST + 1, tr_busy[LAST + 1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
